// File: rtl/cpu_monitor_pkg.sv
// Shared constants for the CPU monitor: host command/reply bytes, FSM state
// encoding and RAM ownership, also usable by host-side test vectors.
package cpu_monitor_pkg;

    localparam logic [7:0] CMD_ADDR    = 8'h41;
    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] CMD_HALT    = 8'h48;
    localparam logic [7:0] CMD_GO      = 8'h47;

    localparam logic [7:0] RSP_ADDR    = 8'h61;
    localparam logic [7:0] RSP_WRITE   = 8'h77;
    localparam logic [7:0] RSP_HALT    = 8'h68;
    localparam logic [7:0] RSP_GO      = 8'h67;
    localparam logic [7:0] RSP_BUSY    = 8'h21;
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADDR_HI = 4'd1,
        ST_ADDR_LO = 4'd2,
        ST_WCNT    = 4'd3,
        ST_WDATA   = 4'd4,
        ST_RCNT    = 4'd5,
        ST_RREQ    = 4'd6,
        ST_RWAIT1  = 4'd7,
        ST_RWAIT2  = 4'd8,
        ST_RSEND   = 4'd9,
        ST_HWAIT   = 4'd10,
        ST_GO      = 4'd11,
        ST_ACK     = 4'd12
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_MON = 1'b1
    } owner_e;

    // A transfer length byte of zero stands for 256 bytes.
    function automatic logic [8:0] count_of(input logic [7:0] n);
        return (n == 8'd0) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/cpu_monitor_mem_port_mux.sv
// Owner-selected RAM port: the CPU passes straight through, or the monitor's
// registered address/data/strobe drive the RAM.
module mem_port_mux
    import cpu_monitor_pkg::*;
#(
    parameter int addr_width = 9
) (
    input  owner_e                  owner_i,
    input  logic [addr_width-1:0]   cpu_raddr_i,
    input  logic [addr_width-1:0]   cpu_waddr_i,
    input  logic [7:0]              cpu_data_i,
    input  logic                    cpu_write_i,
    input  logic [addr_width-1:0]   mon_raddr_i,
    input  logic [addr_width-1:0]   mon_waddr_i,
    input  logic [7:0]              mon_data_i,
    input  logic                    mon_write_i,
    output logic [addr_width-1:0]   mem_raddr_o,
    output logic [addr_width-1:0]   mem_waddr_o,
    output logic [7:0]              mem_data_o,
    output logic                    mem_write_o
);

    always_comb begin
        if (owner_i == OWN_CPU) begin
            mem_raddr_o = cpu_raddr_i;
            mem_waddr_o = cpu_waddr_i;
            mem_data_o  = cpu_data_i;
            mem_write_o = cpu_write_i;
        end else begin
            mem_raddr_o = mon_raddr_i;
            mem_waddr_o = mon_waddr_i;
            mem_data_o  = mon_data_i;
            mem_write_o = mon_write_i;
        end
    end

endmodule

// File: rtl/cpu_monitor.sv
// Host-link monitor: halts/restarts the CPU and loads or dumps program RAM
// over a byte stream. dbg_state_o exposes the command FSM state.
module cpu_monitor
    import cpu_monitor_pkg::*;
#(
    parameter int addr_width = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_busy,
    output logic                    cpu_reset,
    output logic                    cpu_halt,
    input  logic                    cpu_halted,
    output logic [addr_width-1:0]   start_address,
    input  logic [addr_width-1:0]   cpu_raddr,
    input  logic [addr_width-1:0]   cpu_waddr,
    input  logic [7:0]              cpu_data_in,
    input  logic                    cpu_write,
    output logic [addr_width-1:0]   mem_raddr,
    output logic [addr_width-1:0]   mem_waddr,
    output logic [7:0]              mem_data_in,
    output logic                    mem_write,
    input  logic [7:0]              mem_data_out,
    output logic [3:0]              dbg_state_o
);

    state_e                 state_q, state_d;
    owner_e                 owner_q, owner_d;
    logic [addr_width-1:0]  ptr_q, ptr_d;
    logic [addr_width-1:0]  start_q, start_d;
    logic [addr_width-1:0]  raddr_q, raddr_d;
    logic [addr_width-1:0]  waddr_q, waddr_d;
    logic [8:0]             cnt_q, cnt_d;
    logic [7:0]             hi_q, hi_d;
    logic [7:0]             reply_q, reply_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   write_q, write_d;
    logic                   halt_q, halt_d;
    logic                   cpu_reset_q, cpu_reset_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_MON;
            ptr_q       <= '0;
            start_q     <= '0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            reply_q     <= '0;
            wdata_q     <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            write_q     <= 1'b0;
            halt_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            start_q     <= start_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            reply_q     <= reply_d;
            wdata_q     <= wdata_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            write_q     <= write_d;
            halt_q      <= halt_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        start_d     = start_q;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        reply_d     = reply_q;
        wdata_d     = wdata_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;
        write_d     = 1'b0;
        halt_d      = halt_q;
        cpu_reset_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    // Memory commands are refused while the CPU owns the RAM.
                    reply_d = RSP_BUSY;
                    case (rx_data)
                        CMD_ADDR:  state_d = (owner_q == OWN_MON) ? ST_ADDR_HI : ST_ACK;
                        CMD_WRITE: state_d = (owner_q == OWN_MON) ? ST_WCNT : ST_ACK;
                        CMD_READ:  state_d = (owner_q == OWN_MON) ? ST_RCNT : ST_ACK;
                        CMD_HALT: begin
                            halt_d  = 1'b1;
                            state_d = ST_HWAIT;
                        end
                        CMD_GO: begin
                            start_d     = ptr_q;
                            cpu_reset_d = 1'b1;
                            halt_d      = 1'b0;
                            owner_d     = OWN_CPU;
                            state_d     = ST_GO;
                        end
                        default: begin
                            reply_d = RSP_UNKNOWN;
                            state_d = ST_ACK;
                        end
                    endcase
                end
            end
            ST_ADDR_HI: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO: begin
                if (rx_valid) begin
                    ptr_d   = addr_width'({hi_q, rx_data});
                    reply_d = RSP_ADDR;
                    state_d = ST_ACK;
                end
            end
            ST_WCNT: begin
                if (rx_valid) begin
                    cnt_d   = count_of(rx_data);
                    state_d = ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    waddr_d = ptr_q;
                    wdata_d = rx_data;
                    write_d = 1'b1;
                    ptr_d   = ptr_q + addr_width'(1);
                    cnt_d   = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        reply_d = RSP_WRITE;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_RCNT: begin
                if (rx_valid) begin
                    cnt_d   = count_of(rx_data);
                    state_d = ST_RREQ;
                end
            end
            ST_RREQ: begin
                raddr_d = ptr_q;
                state_d = ST_RWAIT1;
            end
            ST_RWAIT1: state_d = ST_RWAIT2;
            ST_RWAIT2: state_d = ST_RSEND;
            ST_RSEND: begin
                if (!tx_busy) begin
                    tx_data_d  = mem_data_out;
                    tx_valid_d = 1'b1;
                    ptr_d      = ptr_q + addr_width'(1);
                    cnt_d      = cnt_q - 9'd1;
                    state_d    = (cnt_q == 9'd1) ? ST_IDLE : ST_RREQ;
                end
            end
            ST_HWAIT: begin
                if (cpu_halted) begin
                    owner_d = OWN_MON;
                    reply_d = RSP_HALT;
                    state_d = ST_ACK;
                end
            end
            ST_GO: begin
                reply_d = RSP_GO;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!tx_busy) begin
                    tx_data_d  = reply_q;
                    tx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mem_port_mux #(.addr_width(addr_width)) u_mux (
        .owner_i     (owner_q),
        .cpu_raddr_i (cpu_raddr),
        .cpu_waddr_i (cpu_waddr),
        .cpu_data_i  (cpu_data_in),
        .cpu_write_i (cpu_write),
        .mon_raddr_i (raddr_q),
        .mon_waddr_i (waddr_q),
        .mon_data_i  (wdata_q),
        .mon_write_i (write_q),
        .mem_raddr_o (mem_raddr),
        .mem_waddr_o (mem_waddr),
        .mem_data_o  (mem_data_in),
        .mem_write_o (mem_write)
    );

    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign cpu_reset     = cpu_reset_q;
    assign cpu_halt      = halt_q;
    assign start_address = start_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/cpu_monitor.md
# cpu_monitor

Byte-stream controller that sequences the CPU core and shares the byte-wide program RAM between the CPU and a host link (UART RX/TX byte interface). On command it halts the CPU, takes the memory port, loads or dumps memory bytes, then restarts the CPU at a chosen address. It sits between the UART, the CPU core and the RAM. It owns the CPU's `reset`, `halt` and `start_address` inputs, and muxes the RAM port.

## Interface
- `addr_width`, default 9: RAM address width; must be ≤ 16.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low.
- `rx_data` in 8: received host byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `tx_data` out 8: byte to host.
- `tx_valid` out 1: one-cycle send strobe.
- `tx_busy` in 1: transmitter busy; `tx_valid` only when low.
- `cpu_reset` out 1: active-high CPU reset pulse.
- `cpu_halt` out 1: CPU halt request.
- `cpu_halted` in 1: CPU halted status.
- `start_address` out `addr_width`: CPU restart address.
- `cpu_raddr`, `cpu_waddr` in `addr_width`: CPU memory addresses.
- `cpu_data_in` in 8: CPU memory write data.
- `cpu_write` in 1: CPU memory write strobe.
- `mem_raddr`, `mem_waddr` out `addr_width`: RAM addresses.
- `mem_data_in` out 8: RAM write data.
- `mem_write` out 1: RAM write strobe.
- `mem_data_out` in 8: RAM read data, also routed unchanged to the CPU.

## Operation
- An `owner` register drives a combinational mux on the `mem_*` outputs.
  - `owner`=CPU: the `cpu_*` memory signals pass through.
  - `owner`=MON: internal signals drive the RAM, and `mem_write` is forced from the internal strobe only.
- Internal pointer `ptr` is `addr_width` bits and increments modulo 2^`addr_width` (wrap-around).
- Commands arrive as bytes and are only accepted in IDLE:
  - 0x41 'A' hi lo: `ptr` ← {hi,lo}[addr_width-1:0]. Reply 0x61.
  - 0x57 'W' n d…: write n data bytes at `ptr`, `ptr`++ after each. n=0 means 256. Reply 0x77 after the last byte.
  - 0x52 'R' n: read n bytes from `ptr` (n=0 means 256) and send each one; `ptr`++ after each. No trailing ack.
  - 0x48 'H': assert `cpu_halt`, wait for `cpu_halted`, then `owner`←MON. Reply 0x68.
  - 0x47 'G': `start_address`←`ptr`, one-cycle `cpu_reset` pulse, drop `cpu_halt`, `owner`←CPU. Reply 0x67.
  - Any other byte: reply 0x3F.
- 'A', 'W' and 'R' while `owner`=CPU: reply 0x21 and do not touch memory. Any operand bytes that follow are then parsed as commands; the host is responsible for that.
- FSM states: IDLE, ADDR_HI, ADDR_LO, WCNT, WDATA, RCNT, RREQ, RWAIT1, RWAIT2, RSEND, HWAIT, GO, ACK.
  - ACK holds the reply byte until `tx_busy`=0, pulses `tx_valid`, then returns to IDLE.
  - WDATA: on `rx_valid`, drive `mem_waddr`=`ptr` and `mem_data_in`=`rx_data`, pulse `mem_write` the next cycle, `ptr`++, decrement the count. Go to ACK when the count reaches 0.
  - RREQ drives `mem_raddr`=`ptr`. RWAIT1 and RWAIT2 follow. RSEND captures `mem_data_out` and sends it when `tx_busy`=0. Then `ptr`++ and either loop to RREQ or go to IDLE.
  - HWAIT has no timeout. If `cpu_halted` is already 1, it completes on the next cycle.
- `rx_valid` arriving in a state that does not consume RX (RREQ…RSEND, HWAIT, GO, ACK) is dropped.
- On reset, and on reset taken mid-operation, everything below is forced. Any in-progress command is aborted and `ptr` is not preserved:
  - `owner`=MON, `cpu_halt`=1, `cpu_reset`=1.
  - `start_address`=0, `ptr`=0.
  - `tx_valid`=0, `tx_data`=0.
  - `mem_write`=0, internal addresses 0.
  - state IDLE.
- `cpu_reset` deasserts on the first cycle after reset is released.

## Timing
- RAM read latency: `mem_data_out` is valid 2 cycles after `mem_raddr` is registered. RREQ → RWAIT1 → RWAIT2 → RSEND samples in the third cycle.
- Write: `mem_write` is high exactly 1 cycle, the cycle after the `rx_valid` that carried the data.
- 'G': `start_address` is registered in the same edge that raises `cpu_reset`. `cpu_reset` is high for exactly 1 cycle. `owner` switches on that same edge, so the CPU fetches from `start_address` right after.
- 'H': `owner` switches the cycle after `cpu_halted` is sampled high. The monitor never drives the RAM while `cpu_halted`=0.
- Minimum one idle cycle between the `tx_valid` pulses.

## Structure
- Shared package or include holds the command and reply byte constants and the state encoding, for reuse by the host tool's test vectors.
- One natural sub-module: `mem_port_mux`, the combinational owner-selected RAM port mux. All other logic is one FSM module.

## Test plan
- Reset, then 'A' 0x00 0x10, then 'W' 0x03 AA BB CC → 3 `mem_write` pulses at 0x10/0x11/0x12 with AA/BB/CC, then tx 0x77.
- 'A' 0x00 0x10, then 'R' 0x03 → tx AA, BB, CC in order. Hold `tx_busy` high for 20 cycles mid-stream: no byte lost or duplicated.
- 'A' 0x01 0xFF (addr_width 9), then 'W' 0x02 11 22 → writes at 0x1FF then 0x000 (wrap).
- 'A' 0x00 0x40, then 'G' → `start_address`=0x040, a single-cycle `cpu_reset`, `cpu_halt`=0, CPU memory traffic visible on `mem_*`, tx 0x67. Then 'W' → tx 0x21 and no `mem_write` from the monitor.
- With the CPU running, 'H' and `cpu_halted` delayed 5 cycles → `owner` is still CPU until the cycle after `cpu_halted`, then tx 0x68.
- Reset asserted in the middle of 'W' after the first data byte → IDLE, `cpu_halt`=1, and no further writes. A following unknown byte 0x00 → tx 0x3F.
